// File: rtl/btb_ctrl_pkg.sv
// Shared definitions for the branch target buffer controller:
// entry layout, field widths, index width and controller states.
package btb_ctrl_pkg;

   localparam int BTB_IDX_W   = 4;
   localparam int TAG_W       = 25;
   localparam int TGT_W       = 30;
   localparam int BTB_ENTRY_W = 1 + TAG_W + TGT_W;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [TGT_W-1:0] target;
   } btb_entry_t;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } btb_state_e;

endpackage

// File: rtl/btb_ctrl.sv
// BTB controller: clears the external SRAM after reset or flush, then
// arbitrates one update or one lookup per cycle onto the single SRAM port.
module btb_ctrl
   import btb_ctrl_pkg::*;
#(
   parameter int IDX_W   = BTB_IDX_W,
   parameter int ENTRY_W = BTB_ENTRY_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               lkp_req,
   input  logic [31:0]        lkp_pc,
   output logic               lkp_rdy,
   output logic               lkp_resp_valid,
   output logic               lkp_hit,
   output logic [31:0]        lkp_target,
   input  logic               upd_req,
   input  logic               upd_clr,
   input  logic [31:0]        upd_pc,
   input  logic [31:0]        upd_target,
   output logic               upd_rdy,
   input  logic               inv_all,
   output logic               sram_csb,
   output logic               sram_web,
   output logic [IDX_W-1:0]   sram_addr,
   output logic [ENTRY_W-1:0] sram_din,
   input  logic [ENTRY_W-1:0] sram_dout
);

   btb_state_e       r_state;
   logic [IDX_W-1:0] r_cnt;
   logic             r_resp_vld;
   logic [TAG_W-1:0] r_tag_q;

   logic       w_run;
   logic       w_init_wr;
   logic       w_upd_go;
   logic       w_lkp_go;
   btb_entry_t w_new;
   btb_entry_t w_rd;
   logic       w_hit;
   logic       w_unused_pc;

   always_comb begin
      w_run     = (r_state == ST_RUN);
      // inv_all drops whatever request shares its cycle
      upd_rdy   = w_run && !inv_all;
      lkp_rdy   = w_run && !inv_all && !upd_req;
      w_upd_go  = upd_req && upd_rdy;
      w_lkp_go  = lkp_req && lkp_rdy;
      w_init_wr = (r_state == ST_INIT) && rst_n;

      w_new.valid  = 1'b1;
      w_new.tag    = upd_pc[30:6];
      w_new.target = upd_target[31:2];

      sram_csb  = 1'b1;
      sram_web  = 1'b1;
      sram_addr = '0;
      sram_din  = '0;
      if (w_init_wr) begin
         sram_csb  = 1'b0;
         sram_web  = 1'b0;
         sram_addr = r_cnt;
      end else if (w_upd_go) begin
         sram_csb  = 1'b0;
         sram_web  = 1'b0;
         sram_addr = upd_pc[2 +: IDX_W];
         sram_din  = upd_clr ? '0 : ENTRY_W'(w_new);
      end else if (w_lkp_go) begin
         sram_csb  = 1'b0;
         sram_addr = lkp_pc[2 +: IDX_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_INIT;
         r_cnt      <= '0;
         r_resp_vld <= 1'b0;
      end else begin
         r_resp_vld <= w_lkp_go;
         case (r_state)
            ST_INIT: begin
               if (inv_all) begin
                  r_cnt <= '0;
               end else if (r_cnt == {IDX_W{1'b1}}) begin
                  r_cnt   <= '0;
                  r_state <= ST_RUN;
               end else begin
                  r_cnt <= r_cnt + IDX_W'(1);
               end
            end
            ST_RUN: begin
               if (inv_all) begin
                  r_cnt   <= '0;
                  r_state <= ST_INIT;
               end
            end
            default: begin
               r_cnt   <= '0;
               r_state <= ST_INIT;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_lkp_go)
         r_tag_q <= lkp_pc[30:6];
   end

   // SRAM read data arrives the cycle after the lookup was issued
   always_comb begin
      w_rd           = sram_dout[BTB_ENTRY_W-1:0];
      w_hit          = r_resp_vld && w_rd.valid && (w_rd.tag == r_tag_q);
      lkp_resp_valid = r_resp_vld;
      lkp_hit        = w_hit;
      lkp_target     = w_hit ? {w_rd.target, 2'b00} : 32'h0;
   end

   assign w_unused_pc = ^{upd_pc[31], upd_pc[1:0], upd_target[1:0],
                          lkp_pc[31], lkp_pc[1:0]};

endmodule
